adder_pipe: RTL and testbench
=============================

Name: adder_pipe

Overview:
- Parametrised, pipelined successor to the 4-bit ripple-carry adder.
- Computes A+B+C_in or A-B-C_in over WIDTH bits, split into STAGES equal chunks.
- Each chunk is ripple-added in its own register stage, and the carry is registered between stages.
- Valid/ready handshake with full backpressure; used as the arithmetic core in datapath blocks that need a wide adder at high clock rate.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of STAGES (elaboration error otherwise)
STAGES, 4, number of pipeline stages (>=1); CHUNK = WIDTH/STAGES bits are added per stage

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat this cycle
a  input  WIDTH  operand A (unsigned or two's complement)
b  input  WIDTH  operand B
c_in  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: A+B+c_in; 1: A-B-c_in
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result bits
c_out  output  1  add: carry-out; sub: 1 = no borrow (A >= B+c_in, unsigned)
ovf  output  1  signed two's-complement overflow of the operation

Behaviour:
- Operand mapping at input: bx = sub ? ~b : b; cx = sub ? ~c_in : c_in.
  - Result is always a + bx + cx.
  - sub with c_in=0 gives A-B.
- Stage k (k=0..STAGES-1):
  - Adds chunk k of a and bx plus the carry from stage k-1 (cx for k=0).
  - Writes result chunk k into its pipeline register.
  - Carries the not-yet-added upper operand bits forward unmodified.
- ovf: taken from the final stage as carry-into-MSB XOR carry-out-of-MSB, registered with the result.
- Latency: exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, with no stall.
- Throughput: one beat per cycle.
- Each stage holds a valid bit; bubbles propagate as invalid stages.
- Stall is global: stall = out_valid & ~out_ready.
  - When stall=1, every stage register, including valid bits, holds its value.
  - in_ready = ~stall; this is a combinational path from out_ready and is documented as such.
- Beats are never dropped, duplicated or reordered.
- out_valid stays high, with sum/c_out/ovf stable, until out_ready is sampled high.
- in_valid=1 while in_ready=0: the beat is not taken; the upstream must hold it.
- Reset (asynchronous, any time, including mid-stream):
  - All valid bits, sum, c_out and ovf clear to 0; in-flight beats are discarded.
  - After reset, in_ready=1 because out_valid=0.
- Outputs are registered from the last stage.
- STAGES=1: single-cycle registered adder, same handshake.
- Wrap-around: sum is modulo 2^WIDTH; the extra bit appears only on c_out.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: a=0xFFFF, b=0x0001, c_in=0, sub=0 → 4 cycles later sum=0x0000, c_out=1, ovf=0, out_valid for exactly 1 cycle.
- Sub: a=0x0005, b=0x0007, c_in=0, sub=1 → sum=0xFFFE, c_out=0, ovf=0. Then a=0x0007, b=0x0005, c_in=1 → sum=0x0001, c_out=1.
- Overflow: a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, ovf=1. Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1, c_out=1.
- Backpressure: stream 8 beats a=i, b=0x1000, in_valid continuously; hold out_ready=0 for 3 cycles mid-stream.
  - in_ready=0 during the stall.
  - Outputs arrive in order 0x1000..0x1007 with none lost or repeated.
- Bubbles: in_valid toggled 1,0,0,1 → out_valid shows the same pattern delayed by 4 cycles; no spurious beats.
- Reset mid-operation: assert rst for 1 cycle with 3 beats in flight → out_valid=0 and outputs 0 immediately (asynchronous). No stale beat emerges afterwards; the next beat has latency 4.

Source files
------------

// File: rtl/adder_pipe.sv
// -----------------------------------------------------------------------------
// adder_pipe
//
// Pipelined wide adder/subtractor. The WIDTH-bit operation is cut into STAGES
// equal chunks of CHUNK = WIDTH/STAGES bits. Each pipeline stage ripple-adds one
// chunk and registers the carry for the next stage. Operand bits that are still
// to be added travel down the pipe alongside the partial result.
//
// Subtraction is folded into addition at the input:
//   result = a + (sub ? ~b : b) + (sub ? ~c_in : c_in)
// so c_out reads as "no borrow" when subtracting.
//
// Handshake: valid/ready with one global stall. When the output holds a beat
// that downstream does not take, every stage freezes. in_ready is the inverse
// of that stall and is therefore a combinational path from out_ready.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset; discards in-flight beats
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle (combinational from out_ready)
//   a, b       operands (unsigned or two's complement), WIDTH bits
//   c_in       carry-in for add, borrow-in for sub
//   sub        0: a+b+c_in   1: a-b-c_in
//   out_valid  result beat valid (registered)
//   out_ready  downstream accepts the result beat
//   sum        result, modulo 2^WIDTH (registered)
//   c_out      add: carry-out; sub: 1 means no borrow (registered)
//   ovf        signed two's-complement overflow (registered)
// -----------------------------------------------------------------------------
module adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  // Guarded copies so that a bad configuration reaches the $error below
  // instead of failing earlier on a divide by zero or a negative range.
  localparam int STG   = (STAGES < 1) ? 1 : STAGES;
  localparam int CHUNK = WIDTH / STG;
  // Forwarded-operand registers exist only between stages; keep at least one
  // entry so the array is legal when the pipe has a single stage.
  localparam int OPS   = (STG > 1) ? (STG - 1) : 1;

  generate
    if ((STAGES < 1) || (WIDTH < 1) || ((WIDTH % STG) != 0)) begin : g_bad_cfg
      $error("adder_pipe: WIDTH must be a positive multiple of STAGES (STAGES >= 1)");
    end
  endgenerate

  // One chunk of ripple-carry addition; returns {carry_out, sum_bits}.
  function automatic logic [CHUNK:0] ripple_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             ci
  );
    logic             c;
    logic [CHUNK-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational signals
  // ---------------------------------------------------------------------------
  logic             stall_s;
  logic [WIDTH-1:0] bx_s;
  logic             cx_s;

  // cur_*_s[k] is what stage k sees this cycle: raw inputs for stage 0,
  // the previous stage's registers otherwise.
  logic [WIDTH-1:0] cur_a_s   [STG];
  logic [WIDTH-1:0] cur_b_s   [STG];
  logic [WIDTH-1:0] cur_res_s [STG];
  logic [STG-1:0]   cur_c_s;
  logic [STG-1:0]   cur_v_s;
  logic [CHUNK:0]   add_s     [STG];
  logic [WIDTH-1:0] res_nxt_s [STG];
  logic             ovf_nxt_s;

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic [STG-1:0]   valid_r;
  logic [STG-1:0]   carry_r;
  logic [WIDTH-1:0] res_r  [STG];
  logic [WIDTH-1:0] op_a_r [OPS];
  logic [WIDTH-1:0] op_b_r [OPS];
  logic             ovf_r;

  // Global stall: the output holds a beat that downstream refuses.
  always_comb begin
    stall_s  = valid_r[STG-1] & ~out_ready;
    in_ready = ~stall_s;
  end

  // Fold subtraction into addition: a - b - c_in == a + ~b + ~c_in.
  always_comb begin
    if (sub) begin
      bx_s = ~b;
      cx_s = ~c_in;
    end else begin
      bx_s = b;
      cx_s = c_in;
    end
  end

  // Per-stage chunk addition and next-state of the partial result.
  always_comb begin
    cur_c_s = '0;
    cur_v_s = '0;
    for (int k = 0; k < STG; k++) begin
      int prev;
      prev          = (k > 0) ? (k - 1) : 0;
      cur_a_s[k]    = '0;
      cur_b_s[k]    = '0;
      cur_res_s[k]  = '0;
      if (k == 0) begin
        cur_a_s[k]   = a;
        cur_b_s[k]   = bx_s;
        cur_c_s[k]   = cx_s;
        cur_v_s[k]   = in_valid;
        cur_res_s[k] = '0;
      end else begin
        cur_a_s[k]   = op_a_r[prev];
        cur_b_s[k]   = op_b_r[prev];
        cur_c_s[k]   = carry_r[prev];
        cur_v_s[k]   = valid_r[prev];
        cur_res_s[k] = res_r[prev];
      end
      // Forwarded operands are shifted so the chunk to add is always at bit 0.
      add_s[k]     = ripple_add(cur_a_s[k][CHUNK-1:0], cur_b_s[k][CHUNK-1:0], cur_c_s[k]);
      res_nxt_s[k] = cur_res_s[k];
      res_nxt_s[k][k*CHUNK +: CHUNK] = add_s[k][CHUNK-1:0];
    end
    // Carry into the MSB equals a_msb ^ bx_msb ^ sum_msb, so signed overflow
    // (carry-in XOR carry-out of the MSB) needs no extra carry tap.
    ovf_nxt_s = cur_a_s[STG-1][CHUNK-1] ^ cur_b_s[STG-1][CHUNK-1]
              ^ add_s[STG-1][CHUNK-1]   ^ add_s[STG-1][CHUNK];
  end

  // Pipeline advance: every stage moves together unless the output is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
      carry_r <= '0;
      ovf_r   <= 1'b0;
      for (int k = 0; k < STG; k++) begin
        res_r[k] <= '0;
      end
      for (int k = 0; k < OPS; k++) begin
        op_a_r[k] <= '0;
        op_b_r[k] <= '0;
      end
    end else if (!stall_s) begin
      valid_r <= cur_v_s;
      // Data registers load only for real beats, so a bubble leaves the last
      // result visible (with out_valid low) instead of toggling the datapath.
      for (int k = 0; k < STG; k++) begin
        if (cur_v_s[k]) begin
          res_r[k]   <= res_nxt_s[k];
          carry_r[k] <= add_s[k][CHUNK];
        end
      end
      for (int k = 0; k < STG - 1; k++) begin
        if (cur_v_s[k]) begin
          op_a_r[k] <= cur_a_s[k] >> CHUNK;
          op_b_r[k] <= cur_b_s[k] >> CHUNK;
        end
      end
      if (cur_v_s[STG-1]) begin
        ovf_r <= ovf_nxt_s;
      end
    end
  end

  // Outputs come straight from the last stage's registers.
  assign out_valid = valid_r[STG-1];
  assign sum       = res_r[STG-1];
  assign c_out     = carry_r[STG-1];
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_adder_pipe.sv
// -----------------------------------------------------------------------------
// tb_adder_pipe
//
// Self-checking bench for adder_pipe (WIDTH=16, STAGES=4). Expected results
// come from a plain-arithmetic model (signed/unsigned integer math) queued at
// the moment a beat is accepted; results are popped when downstream takes
// them. Directed beats carry literal expected values.
// -----------------------------------------------------------------------------
module tb_adder_pipe;

  localparam int     W    = 16;
  localparam int     S    = 4;
  localparam longint MAXS = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam longint MINS = -(64'sd1 <<< (W - 1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;

  adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests   = 0;
  int         n_fail    = 0;
  bit         dir_use   = 1'b0;
  bit         lat_en    = 1'b0;
  bit         head_seen = 1'b0;
  bit         last_in_ready;
  exp_t       dir_exp;
  logic [7:0] ov_hist   = 8'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: the arithmetic the block is meant to perform, in wide integers.
  function automatic exp_t model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                 input logic ci, input logic s);
    exp_t   e;
    longint ua, ub, sa, sb, r, sr, lci;
    ua  = longint'(xa);
    ub  = longint'(xb);
    sa  = longint'(signed'(xa));
    sb  = longint'(signed'(xb));
    lci = longint'(ci);
    if (!s) begin
      r   = ua + ub + lci;
      sr  = sa + sb + lci;
      e.c = (r >= (64'sd1 <<< W));
    end else begin
      r   = ua - ub - lci;
      sr  = sa - sb - lci;
      e.c = (ua >= ub + lci);
    end
    e.sum = r[W-1:0];
    e.o   = (sr > MAXS) || (sr < MINS);
    e.acc = 0;
    return e;
  endfunction

  // One clock cycle: sample at the falling edge, score the output, record an
  // accepted input, then return 1 time unit after the next rising edge.
  task automatic run_cycle(output bit acc);
    exp_t e;
    @(negedge clk);
    acc           = in_valid && in_ready;
    last_in_ready = in_ready;
    check_eq("no_spurious", {31'd0, out_valid && (exp_q.size() == 0)}, 32'd0);
    if (out_valid && (exp_q.size() > 0)) begin
      if (lat_en && !head_seen) begin
        check_eq("latency", cyc - exp_q[0].acc, S);
      end
      head_seen = 1'b1;
      if (out_ready) begin
        e = exp_q.pop_front();
        check_eq("sum", sum, e.sum);
        check_eq("c_out", c_out, e.c);
        check_eq("ovf", ovf, e.o);
        head_seen = 1'b0;
      end
    end
    ov_hist = {ov_hist[6:0], out_valid};
    if (acc) begin
      e     = dir_use ? dir_exp : model(a, b, c_in, sub);
      e.acc = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_dir(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic ci,
                          input logic s, input logic [W-1:0] es, input logic ec, input logic eo);
    bit acc;
    a = xa; b = xb; c_in = ci; sub = s; in_valid = 1'b1;
    dir_use     = 1'b1;
    dir_exp.sum = es;
    dir_exp.c   = ec;
    dir_exp.o   = eo;
    dir_exp.acc = 0;
    run_cycle(acc);
    check_eq("accept", acc, 1);
    in_valid = 1'b0;
    dir_use  = 1'b0;
  endtask

  task automatic send_rand();
    bit acc;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    in_valid = 1'b1;
    dir_use  = 1'b0;
    run_cycle(acc);
    check_eq("accept", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) run_cycle(acc);
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; (i < 60) && (exp_q.size() > 0); i++) run_cycle(acc);
    check_eq("drain", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int nbeat;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sum", sum, 0);
    check_eq("rst_c_out", c_out, 0);
    check_eq("rst_ovf", ovf, 0);
    check_eq("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Wrap-around carry, and out_valid lasting one cycle.
    lat_en = 1'b1;
    send_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    idle(6);
    check_eq("one_cycle_valid", ov_hist[6:0], 7'b0000100);

    // Subtraction with and without borrow-in.
    send_dir(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_dir(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    idle(6);

    // Signed overflow in both directions.
    send_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_dir(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    idle(6);

    // Bubbles: input pattern 1,0,0,1 reappears 4 cycles later.
    send_rand();
    idle(2);
    send_rand();
    idle(4);
    check_eq("bubble_pattern", ov_hist, 8'b0000_1001);

    // Backpressure: continuous stream, out_ready low for 3 cycles mid-stream.
    lat_en = 1'b0;
    nbeat  = 0;
    for (int t = 0; (t < 40) && (nbeat < 8); t++) begin
      a = W'(nbeat); b = 16'h1000; c_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
      dir_use     = 1'b1;
      dir_exp.sum = 16'h1000 + W'(nbeat);
      dir_exp.c   = 1'b0;
      dir_exp.o   = 1'b0;
      out_ready   = !((t >= 6) && (t <= 8));
      run_cycle(acc);
      check_eq("in_ready_bp", last_in_ready, out_ready);
      if (acc) nbeat++;
    end
    check_eq("bp_beats_sent", nbeat, 8);
    dir_use = 1'b0;
    drain();

    // Asynchronous reset with beats in flight.
    lat_en = 1'b1;
    send_dir(16'hC000, 16'h9000, 1'b0, 1'b0, 16'h5000, 1'b1, 1'b1);
    idle(5);
    send_rand();
    send_rand();
    send_rand();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_out_valid", out_valid, 0);
    check_eq("arst_sum", sum, 0);
    check_eq("arst_c_out", c_out, 0);
    check_eq("arst_ovf", ovf, 0);
    exp_q.delete();
    head_seen = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(6);
    send_dir(16'h1234, 16'h0101, 1'b1, 1'b0, 16'h1336, 1'b0, 1'b0);
    idle(6);

    // Randomized traffic with random backpressure; upstream holds refused beats.
    lat_en   = 1'b0;
    acc      = 1'b1;
    in_valid = 1'b0;
    for (int t = 0; t < 400; t++) begin
      if (!in_valid || acc) begin
        in_valid = (($urandom % 4) != 0);
        a    = W'($urandom);
        b    = W'($urandom);
        c_in = 1'($urandom);
        sub  = 1'($urandom);
      end
      out_ready = (($urandom % 10) < 7);
      run_cycle(acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
